// File: rtl/switch_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module  : switch_reader_pkg
// Brief   : Shared IO register offsets and switch bank geometry.
// Revision: 1.0
// ============================================================================
package switch_reader_pkg;

    localparam int IO_BANK_WIDTH = 8;
    localparam int IO_NUM_BANKS  = 3;

    typedef enum logic [1:0] {
        IO_REG_SW_LOW   = 2'b00,
        IO_REG_STATUS   = 2'b01,
        IO_REG_SW_HIGH  = 2'b10,
        IO_REG_RESERVED = 2'b11
    } io_reg_e;

    localparam logic [1:0] IO_ADDR_SW_LOW  = 2'b00;
    localparam logic [1:0] IO_ADDR_STATUS  = 2'b01;
    localparam logic [1:0] IO_ADDR_SW_HIGH = 2'b10;

endpackage
`default_nettype wire

// File: rtl/switch_debounce.sv
`default_nettype none
// ============================================================================
// Module  : switch_debounce
// Brief   : One 8-bit switch bank: 2-flop synchronizer plus counter debounce.
// Revision: 1.0
// ============================================================================
module switch_debounce
    import switch_reader_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [IO_BANK_WIDTH-1:0] raw,
    output logic [IO_BANK_WIDTH-1:0] stable,
    output logic                     stable_change
);

    localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [IO_BANK_WIDTH-1:0] sync_meta;
    logic [IO_BANK_WIDTH-1:0] sync_out;
    logic [IO_BANK_WIDTH-1:0] candidate;
    logic [CNT_W-1:0]         count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= '0;
            sync_out  <= '0;
        end else begin
            sync_meta <= raw;
            sync_out  <= sync_meta;
        end
    end

    // Stable is loaded whenever the counter sits at its terminal value;
    // the counter saturates there instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            candidate <= '0;
            count     <= '0;
            stable    <= '0;
        end else begin
            if (count == CNT_MAX) begin
                stable <= candidate;
            end
            if (sync_out != candidate) begin
                candidate <= sync_out;
                count     <= '0;
            end else if (count != CNT_MAX) begin
                count <= count + CNT_W'(1);
            end
        end
    end

    assign stable_change = (count == CNT_MAX) && (candidate != stable);

endmodule
`default_nettype wire

// File: rtl/switch_reader.sv
`default_nettype none
// ============================================================================
// Module  : switch_reader
// Brief   : Debounced 24-bit DIP switch reader with sticky change flag.
// Revision: 1.0
// ============================================================================
module switch_reader
    import switch_reader_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic        iCpuClock,
    input  logic        iCpuResetN,
    input  logic        iDoIORead,
    input  logic        iDoSwitchRead,
    input  logic [1:0]  iSwitchAddress,
    input  logic [23:0] iFpgaSwitches,
    output logic [15:0] oSwitchReadData,
    output logic        oSwitchChanged
);

    logic [IO_BANK_WIDTH-1:0] bank_stable [IO_NUM_BANKS];
    logic [IO_NUM_BANKS-1:0]  bank_change;
    logic                     read_en;
    logic                     status_clear;
    logic                     changed_flag;

    generate
        for (genvar b = 0; b < IO_NUM_BANKS; b++) begin : g_bank
            switch_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk          (iCpuClock),
                .rst_n        (iCpuResetN),
                .raw          (iFpgaSwitches[b*IO_BANK_WIDTH +: IO_BANK_WIDTH]),
                .stable       (bank_stable[b]),
                .stable_change(bank_change[b])
            );
        end
    endgenerate

    assign read_en      = iDoIORead && iDoSwitchRead;
    assign status_clear = read_en && (iSwitchAddress == IO_ADDR_STATUS);

    // A new stable value outranks a coincident status-read clear.
    always_ff @(posedge iCpuClock or negedge iCpuResetN) begin
        if (!iCpuResetN) begin
            changed_flag <= 1'b0;
        end else if (|bank_change) begin
            changed_flag <= 1'b1;
        end else if (status_clear) begin
            changed_flag <= 1'b0;
        end
    end

    always_comb begin
        oSwitchReadData = 16'h0000;
        if (read_en) begin
            case (io_reg_e'(iSwitchAddress))
                IO_REG_SW_LOW:  oSwitchReadData = {bank_stable[1], bank_stable[0]};
                IO_REG_SW_HIGH: oSwitchReadData = {8'h00, bank_stable[2]};
                IO_REG_STATUS:  oSwitchReadData = {15'b0, changed_flag};
                default:        oSwitchReadData = 16'h0000;
            endcase
        end
    end

    assign oSwitchChanged = changed_flag;

endmodule
`default_nettype wire

// File: doc/switch_reader.md
SWITCH_READER -- requirements
Module: switch_reader

Interface
REQ-001 The block SHALL have one parameter: DEBOUNCE_CYCLES, default 20000, the number of consecutive stable clock cycles required to accept a new switch value (minimum 2).
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 Port list:
- iCpuClock  input  1  CPU clock; all state updates on its rising edge.
- iCpuResetN  input  1  asynchronous active-low reset.
- iDoIORead  input  1  IO read strobe from memorio.
- iDoSwitchRead  input  1  switch chip select from memorio.
- iSwitchAddress  input  2  register select (low address bits).
- iFpgaSwitches  input  24  raw board DIP switches; asynchronous to iCpuClock.
- oSwitchReadData  output  16  read data to the CPU.
- oSwitchChanged  output  1  sticky flag; the debounced value has changed since the last status read.

Function
REQ-004 Each switch bit SHALL pass through a 2-flop synchronizer before any other logic uses it.
REQ-005 Debounce SHALL operate per 8-bit bank (bank0 = [7:0], bank1 = [15:8], bank2 = [23:16]):
- each bank holds a candidate register, a stable register and a counter;
- synchronized bank differs from candidate: candidate <= synchronized value, counter <= 0;
- synchronized bank equals candidate and counter < DEBOUNCE_CYCLES-1: counter increments;
- counter == DEBOUNCE_CYCLES-1: stable <= candidate, and the counter holds (no wrap).
REQ-006 Latency from a clean input edge to the stable register update SHALL be exactly 2 + DEBOUNCE_CYCLES + 1 cycles.
REQ-007 A glitch shorter than DEBOUNCE_CYCLES cycles SHALL never reach the stable register.
REQ-008 Read decode SHALL be active only when iDoIORead && iDoSwitchRead; otherwise oSwitchReadData = 16'h0000.
REQ-009 Read map (combinational, same cycle as the strobe):
- 2'b00: {stable bank1, stable bank0}
- 2'b10: {8'h00, stable bank2}
- 2'b01: {15'b0, changed flag}
- 2'b11: 16'h0000
REQ-010 The changed flag SHALL set on the clock edge where any bank's stable register takes a value different from its previous value.
REQ-011 The changed flag SHALL clear on the clock edge that ends a decoded read of address 2'b01.
REQ-012 If a set condition and a status-read clear occur in the same cycle, the set SHALL win (flag = 1).
REQ-013 oSwitchChanged SHALL equal the changed flag register.
REQ-014 Reads SHALL have no side effects except the clear in REQ-011.

Reset
REQ-015 When iCpuResetN = 0, the following SHALL be forced to 0 immediately, independent of the clock: synchronizer flops, candidates, stable registers, counters and the changed flag.
REQ-016 Consequently, while in reset, oSwitchChanged = 0 and every read returns 16'h0000.
REQ-017 After reset deassertion, switches already on SHALL be accepted after REQ-006 latency and SHALL set the changed flag.
REQ-018 Reset asserted mid-debounce SHALL discard the partial count; no stale value SHALL be accepted after release.

Structure
REQ-019 The IO register offsets (2'b00, 2'b01, 2'b10) and the bank width (8) SHALL be defined as constants in the shared IO package used by the LED driver.
REQ-020 One sub-module, switch_debounce (8-bit synchronizer + candidate/stable/counter, parameterized by DEBOUNCE_CYCLES), SHALL be instantiated three times.
REQ-021 The counter width SHALL be $clog2(DEBOUNCE_CYCLES).
REQ-022 All state SHALL live in the sub-modules except the changed flag and read mux.

Verification (DEBOUNCE_CYCLES = 4)
REQ-023 Reset scenario: reset held, switches = 24'hFFFFFF, read addr 00 -> 16'h0000; oSwitchChanged = 0.
REQ-024 Clean change: set switches = 24'hA5_3C_96 -> after 7 cycles, read 00 = 16'h3C96, read 10 = 16'h00A5, oSwitchChanged = 1.
REQ-025 Glitch rejection: bit 0 pulses high for 3 cycles -> stable bank0 stays 8'h00; oSwitchChanged remains 0.
REQ-026 Status clear: flag = 1, decoded read addr 01 -> data 16'h0001; next cycle flag = 0; a second read returns 16'h0000.
REQ-027 Set beats clear: status read coincident with a stable update of bank2 -> flag = 1 after that edge.
REQ-028 Deselect and mid-debounce reset:
- iDoSwitchRead = 0 with iDoIORead = 1 -> data 16'h0000.
- reset pulsed at count 2 -> no update until a full 7 cycles after release.
